serial_alu_ctrl: RTL and testbench

Sequencer for a bit-serial ALU built from the flexible-logic cell set: XOR/NAND, MX2 and DFFC flops. It latches two WIDTH-bit operands and walks them LSB-first through a single 1-bit datapath, one bit per clock, keeping a carry flop between bits. It exposes a start/busy/done handshake to the core's control unit, so area stays minimal at the cost of WIDTH-cycle latency. It sits between the instruction decoder and the register file of the small cores.

---
 rtl/serial_alu_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_alu_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: latches two operands and processes them LSB-first
// through a 1-bit datapath with a carry flop, behind a start/busy/done handshake.
module serial_alu_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 3
) (
    input  logic             CLK,
    input  logic             CL,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero
);

    localparam logic [1:0]    OP_ADD = 2'b00;
    localparam logic [1:0]    OP_SUB = 2'b01;
    localparam logic [1:0]    OP_XOR = 2'b10;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             busy_d, done_d;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [1:0]       op_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_bit;
    logic             arith;
    logic             b_bit;
    logic             s_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] y_nxt;

    // State register
    always_ff @(posedge CLK or posedge CL) begin
        if (CL) state_q <= IDLE;
        else    state_q <= state_d;
    end

    // Next-state logic; a start seen in RUN is simply dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state, then registered below
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_d == RUN)  busy_d = 1'b1;
        if (state_d == DONE) done_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge CL) begin
        if (CL) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    assign accept   = start && (state_q != RUN);
    assign last_bit = (state_q == RUN) && (cnt == LAST);

    // One-bit datapath; SUB is A + ~B + 1 with the +1 preloaded into carry
    always_comb begin
        arith     = (op_q == OP_ADD) || (op_q == OP_SUB);
        b_bit     = b_sr[0] ^ (op_q == OP_SUB);
        carry_nxt = (a_sr[0] & b_bit) | (a_sr[0] & carry) | (b_bit & carry);
        if (arith)              s_bit = a_sr[0] ^ b_bit ^ carry;
        else if (op_q == OP_XOR) s_bit = a_sr[0] ^ b_sr[0];
        else                    s_bit = ~(a_sr[0] & b_sr[0]);
        y_nxt = {s_bit, y[WIDTH-1:1]};
    end

    always_ff @(posedge CLK or posedge CL) begin
        if (CL) begin
            a_sr  <= '0;
            b_sr  <= '0;
            op_q  <= OP_ADD;
            carry <= 1'b0;
            cnt   <= '0;
            y     <= '0;
            cout  <= 1'b0;
            zero  <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            op_q  <= op;
            carry <= (op == OP_SUB);
            cnt   <= '0;
            y     <= '0;
        end else if (state_q == RUN) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            y    <= y_nxt;
            cnt  <= cnt + CW'(1);
            if (arith) carry <= carry_nxt;
            if (last_bit) begin
                cout <= arith & carry_nxt;
                zero <= (y_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed plus random checks of serial_alu_ctrl against an arithmetic reference model.
module tb_serial_alu_ctrl;

    localparam int unsigned W = 8;

    logic         CLK;
    logic         CL;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         cout;
    logic         zero;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] e_y;
    logic         e_c;
    logic         e_z;

    serial_alu_ctrl #(.WIDTH(W), .CW(3)) dut (
        .CLK(CLK), .CL(CL), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .cout(cout), .zero(zero)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modulo arithmetic; SUB carry means no borrow
    task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        int unsigned s;
        case (o)
            2'b00: begin s = int'(x) + int'(z); e_y = W'(s); e_c = (s >= 256); end
            2'b01: begin e_y = W'(x - z); e_c = (x >= z); end
            2'b10: begin e_y = x ^ z; e_c = 1'b0; end
            default: begin e_y = ~(x & z); e_c = 1'b0; end
        endcase
        e_z = (e_y == '0);
    endtask

    // Drive a request at the falling edge so the next rising edge accepts it
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        @(negedge CLK);
        start = 1'b1; op = o; a = x; b = z;
        model(o, x, z);
    endtask

    task automatic scramble();
        a  = W'($urandom);
        b  = W'($urandom);
        op = 2'($urandom);
    endtask

    // Follow one op from its accept edge to the done pulse; optionally chain the next op
    task automatic track(input bit glitch, input bit chain,
                         input logic [1:0] no, input logic [W-1:0] na, input logic [W-1:0] nb);
        @(posedge CLK);
        #1 start = 1'b0;
        scramble();
        for (int i = 0; i < int'(W); i++) begin
            @(negedge CLK);
            check("busy_run", 32'(busy), 32'd1);
            check("done_run", 32'(done), 32'd0);
            start = (glitch && (i == 2 || i == 4)) || (chain && i == int'(W) - 1);
            scramble();
        end
        @(negedge CLK);
        check("busy_done", 32'(busy), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        check("y", 32'(y), 32'(e_y));
        check("cout", 32'(cout), 32'(e_c));
        check("zero", 32'(zero), 32'(e_z));
        if (chain) begin
            start = 1'b1; op = no; a = na; b = nb;
            model(no, na, nb);
        end else begin
            start = 1'b0;
            @(negedge CLK);
            check("done_once", 32'(done), 32'd0);
            check("busy_idle", 32'(busy), 32'd0);
            check("y_hold", 32'(y), 32'(e_y));
            check("cout_hold", 32'(cout), 32'(e_c));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_y"}, 32'(y), 32'd0);
        check({tag, "_cout"}, 32'(cout), 32'd0);
        check({tag, "_zero"}, 32'(zero), 32'd0);
    endtask

    initial begin
        CL = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        #3 check_reset_outputs("por");
        @(negedge CLK); CL = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check_reset_outputs("idle");
        end

        launch(2'b00, 8'h5A, 8'h3C); track(1'b0, 1'b0, 2'b00, '0, '0);
        launch(2'b00, 8'hFF, 8'h01); track(1'b0, 1'b0, 2'b00, '0, '0);
        launch(2'b01, 8'h10, 8'h01); track(1'b0, 1'b0, 2'b00, '0, '0);
        launch(2'b01, 8'h01, 8'h02); track(1'b0, 1'b0, 2'b00, '0, '0);
        launch(2'b10, 8'hAA, 8'hAA); track(1'b0, 1'b0, 2'b00, '0, '0);
        launch(2'b11, 8'hF0, 8'hFF); track(1'b0, 1'b0, 2'b00, '0, '0);

        // Starts during RUN are dropped
        launch(2'b00, 8'h21, 8'h43); track(1'b1, 1'b0, 2'b00, '0, '0);

        // Start held through DONE: next op accepted with no IDLE cycle
        launch(2'b01, 8'h80, 8'h7F);
        track(1'b0, 1'b1, 2'b00, 8'h33, 8'h44);
        track(1'b0, 1'b0, 2'b00, '0, '0);

        // Reset during random activity clears outputs without a clock edge
        launch(2'($urandom), W'($urandom), W'($urandom));
        @(posedge CLK); #1 start = 1'b0;
        repeat (2) @(posedge CLK);
        #2 CL = 1'b1;
        #1 check_reset_outputs("rst_async");
        @(negedge CLK); CL = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check_reset_outputs("rst_rel");
        end

        // Abort an ADD at E0+4, then confirm no stale done and a clean restart
        launch(2'b00, 8'h12, 8'h34);
        @(posedge CLK); #1 start = 1'b0;
        repeat (4) @(posedge CLK);
        #1 CL = 1'b1;
        #1 check_reset_outputs("abort");
        @(negedge CLK); CL = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_no_busy", 32'(busy), 32'd0);
        end
        launch(2'b00, 8'h01, 8'h01); track(1'b0, 1'b0, 2'b00, '0, '0);

        for (int k = 0; k < 24; k++) begin
            launch(2'($urandom), W'($urandom), W'($urandom));
            track(1'($urandom), 1'b0, 2'b00, '0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
